// File: rtl/filter_pkg.sv
// Shared definitions for the filter front end: pixel width, feeder FSM encoding
// and the padding geometry derived from the kernel size.
package filter_pkg;

    localparam int unsigned PIXEL_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int unsigned calc_pad(input int unsigned kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

    function automatic int unsigned calc_row_len(input int unsigned width,
                                                 input int unsigned kernel_size);
        return width + 2 * calc_pad(kernel_size);
    endfunction

    function automatic int unsigned calc_total_rows(input int unsigned height,
                                                    input int unsigned kernel_size,
                                                    input int unsigned flush_rows);
        return height + 2 * calc_pad(kernel_size) + flush_rows;
    endfunction

    // One spare count value so "x - pad < n" range tests never alias.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/filter_frame_feeder.sv
// Wraps an upstream raster in a zero border of kernel pad width plus trailing
// flush rows, emitting one pixel per cycle on border positions.
module filter_frame_feeder
    import filter_pkg::*;
#(
    parameter int unsigned width       = 320,
    parameter int unsigned height      = 240,
    parameter int unsigned kernel_size = 3,
    parameter int unsigned flush_rows  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iStart,
    input  logic               iValid,
    input  logic [PIXEL_W-1:0] iData,
    output logic               oReady,
    output logic               oValid,
    output logic [PIXEL_W-1:0] oData,
    output logic               oBusy,
    output logic               oDone
);

    localparam int unsigned PAD        = calc_pad(kernel_size);
    localparam int unsigned ROW_LEN    = calc_row_len(width, kernel_size);
    localparam int unsigned TOTAL_ROWS = calc_total_rows(height, kernel_size, flush_rows);
    localparam int unsigned RUN_ROWS   = height + 2 * PAD;
    localparam int unsigned COL_W      = cnt_width(ROW_LEN);
    localparam int unsigned ROW_W      = cnt_width(TOTAL_ROWS);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic data_pos_c;
    logic emit_c;
    logic col_last_c;
    logic run_end_c;
    logic frame_end_c;

    // Modular subtraction folds the lower and upper bound into one compare.
    always_comb begin
        data_pos_c  = ((col - COL_W'(PAD)) < COL_W'(width)) &&
                      ((row - ROW_W'(PAD)) < ROW_W'(height));
        emit_c      = (state == FLUSH) ||
                      ((state == RUN) && (!data_pos_c || iValid));
        col_last_c  = (col == COL_W'(ROW_LEN - 1));
        run_end_c   = col_last_c && (row == ROW_W'(RUN_ROWS - 1));
        frame_end_c = col_last_c && (row == ROW_W'(TOTAL_ROWS - 1));
    end

    assign oReady = (state == RUN) && data_pos_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            oValid <= 1'b0;
            oData  <= '0;
            oDone  <= 1'b0;
            oBusy  <= 1'b0;
        end else begin
            oValid <= 1'b0;
            oDone  <= 1'b0;
            oBusy  <= (state != IDLE) || iStart;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                RUN, FLUSH: begin
                    if (emit_c) begin
                        oValid <= 1'b1;
                        oData  <= ((state == RUN) && data_pos_c) ? iData : '0;
                        if (col_last_c) begin
                            col <= '0;
                            row <= row + 1'b1;
                            // Frame end is tested first so flush_rows=0 exits RUN directly.
                            if (frame_end_c) begin
                                state <= IDLE;
                                row   <= '0;
                                oDone <= 1'b1;
                            end else if (run_end_c) begin
                                state <= FLUSH;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_frame_feeder.sv
// Directed bench for filter_frame_feeder: 4x3 image, 3x3 kernel, with and
// without a flush row, driven from a shared stimulus.
module tb_filter_frame_feeder;

    logic        clk;
    logic        reset;
    logic        iStart;
    logic        iValid;
    logic [23:0] iData;
    logic        oReady, oValid, oBusy, oDone;
    logic [23:0] oData;
    logic        o0Ready, o0Valid, o0Busy, o0Done;
    logic [23:0] o0Data;

    filter_frame_feeder #(.width(4), .height(3), .kernel_size(3), .flush_rows(1)) dut (
        .clk(clk), .reset(reset), .iStart(iStart), .iValid(iValid), .iData(iData),
        .oReady(oReady), .oValid(oValid), .oData(oData), .oBusy(oBusy), .oDone(oDone)
    );

    filter_frame_feeder #(.width(4), .height(3), .kernel_size(3), .flush_rows(0)) dut0 (
        .clk(clk), .reset(reset), .iStart(iStart), .iValid(iValid), .iData(iData),
        .oReady(o0Ready), .oValid(o0Valid), .oData(o0Data), .oBusy(o0Busy), .oDone(o0Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Results of the most recent run_frame call.
    int q_cnt, q0_cnt, rdy_cnt, done_cnt, done0_cnt, done_idx, done0_idx;
    int stall_err, data_err, data0_err, busy_err, first_rdy_str, ptr, timeout;

    typedef struct {
        int    mode;      // 0: iValid held, 1: iValid toggles, 2: iValid held + iStart at cycle 10
        string name;
        int    exp_str;
        int    exp_str0;
        int    exp_rdy;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int n);
        return {8'(n), 8'(255 - n), 8'(n + 64)};
    endfunction

    // Expected k-th strobe of the 6x6 padded frame.
    function automatic logic [23:0] exp_out(input int k);
        int r, c;
        r = k / 6;
        c = k % 6;
        if (r >= 1 && r <= 3 && c >= 1 && c <= 4) return pix((r - 1) * 4 + c);
        return 24'h0;
    endfunction

    task automatic run_frame(input int mode, input int abort_at);
        logic rdy, dprev, d0prev, post;
        q_cnt = 0; q0_cnt = 0; rdy_cnt = 0; done_cnt = 0; done0_cnt = 0;
        done_idx = -1; done0_idx = -1; stall_err = 0; data_err = 0; data0_err = 0;
        busy_err = 0; first_rdy_str = -1; ptr = 0; timeout = 1;
        dprev = 1'b0; d0prev = 1'b0; post = 1'b0;
        @(negedge clk);
        iStart = 1'b1;
        iValid = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            iStart = (mode == 2 && cyc == 10);
            iValid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            iData  = pix(ptr + 1);
            #1;
            rdy = oReady;
            if (rdy) begin
                rdy_cnt++;
                if (first_rdy_str < 0) first_rdy_str = q_cnt;
            end
            @(posedge clk);
            #1;
            if (rdy && iValid) ptr++;
            if (rdy && !iValid && oValid) stall_err++;
            if (oValid) begin
                if (oData !== exp_out(q_cnt)) data_err++;
                q_cnt++;
            end
            if (o0Valid) begin
                if (o0Data !== exp_out(q0_cnt)) data0_err++;
                q0_cnt++;
            end
            if (oBusy !== !dprev) busy_err++;
            if (o0Busy !== !d0prev) busy_err++;
            if (oDone) begin done_cnt++; done_idx = q_cnt; end
            if (o0Done) begin done0_cnt++; done0_idx = q0_cnt; end
            if (abort_at > 0 && q_cnt == abort_at) begin
                timeout = 0;
                break;
            end
            if (post) begin
                timeout = 0;
                break;
            end
            if (dprev) post = 1'b1;
            dprev  = dprev || oDone;
            d0prev = d0prev || o0Done;
            if (dprev && !post) begin
                // sample one more cycle to see oBusy fall
            end
        end
        iStart = 1'b0;
        iValid = 1'b0;
    endtask

    task automatic check_frame(input string name, input int exp_str, input int exp_str0,
                               input int exp_rdy);
        check({name, "_timeout"}, 32'(timeout), 0);
        check({name, "_strobes"}, 32'(q_cnt), 32'(exp_str));
        check({name, "_strobes_f0"}, 32'(q0_cnt), 32'(exp_str0));
        check({name, "_ready_cycles"}, 32'(rdy_cnt), 32'(exp_rdy));
        check({name, "_consumed"}, 32'(ptr), 12);
        check({name, "_data_err"}, 32'(data_err), 0);
        check({name, "_data_err_f0"}, 32'(data0_err), 0);
        check({name, "_stall_err"}, 32'(stall_err), 0);
        check({name, "_busy_err"}, 32'(busy_err), 0);
        check({name, "_done_count"}, 32'(done_cnt), 1);
        check({name, "_done_at"}, 32'(done_idx), 32'(exp_str));
        check({name, "_done_count_f0"}, 32'(done0_cnt), 1);
        check({name, "_done_at_f0"}, 32'(done0_idx), 32'(exp_str0));
    endtask

    initial begin
        int idle_err, ghost_done;
        vecs[0] = '{mode: 0, name: "held",   exp_str: 36, exp_str0: 30, exp_rdy: 12};
        vecs[1] = '{mode: 1, name: "toggle", exp_str: 36, exp_str0: 30, exp_rdy: 24};
        vecs[2] = '{mode: 2, name: "restart_ignored", exp_str: 36, exp_str0: 30, exp_rdy: 12};

        reset = 1'b1; iStart = 1'b0; iValid = 1'b0; iData = 24'h0;
        #12;
        check("rst_oValid", 32'(oValid), 0);
        check("rst_oData", 32'(oData), 0);
        check("rst_oDone", 32'(oDone), 0);
        check("rst_oBusy", 32'(oBusy), 0);
        check("rst_oReady", 32'(oReady), 0);
        @(negedge clk);
        reset = 1'b0;

        // Upstream offers data while idle: nothing accepted, nothing emitted.
        idle_err = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iValid = 1'b1;
            iData  = 24'hABCDEF;
            #1;
            if (oReady !== 1'b0) idle_err++;
            @(posedge clk);
            #1;
            if (oValid !== 1'b0 || oBusy !== 1'b0) idle_err++;
        end
        iValid = 1'b0;
        check("idle_no_accept", 32'(idle_err), 0);

        for (int v = 0; v < 3; v++) begin
            run_frame(vecs[v].mode, 0);
            check_frame(vecs[v].name, vecs[v].exp_str, vecs[v].exp_str0, vecs[v].exp_rdy);
            check({vecs[v].name, "_first_ready_at"}, 32'(first_rdy_str), 7);
            repeat (3) @(negedge clk);
        end

        // Abort during row 2, then confirm no late oDone and a clean restart.
        run_frame(0, 14);
        check("abort_reached", 32'(timeout), 0);
        #2;
        reset = 1'b1;
        #1;
        check("abort_rst_oValid", 32'(oValid), 0);
        check("abort_rst_oBusy", 32'(oBusy), 0);
        check("abort_rst_oReady", 32'(oReady), 0);
        check("abort_rst_oData", 32'(oData), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ghost_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (oDone || o0Done || oValid || o0Valid) ghost_done++;
        end
        check("abort_no_done", 32'(ghost_done), 0);
        run_frame(0, 0);
        check_frame("after_abort", 36, 30, 12);
        check("after_abort_first_ready_at", 32'(first_rdy_str), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
